// File: rtl/ysyx_22040931_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040931_lsu_ctrl
//
// Purpose:
//   Data-memory access controller directly downstream of the MEM stage.
//   It takes one load or store request from the pipeline and runs it as a
//   single transaction on a valid/ready data bus. Load data is returned
//   right-justified on mem_data, with the addressed byte at bit 0, so the MEM
//   stage can sign- or zero-extend it. stall_o holds the pipeline until the
//   access completes.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_ena         access request from the MEM stage
//   mem_wr          1 = store, 0 = load
//   memop           access size: 00=B 01=H 10=W 11=D
//   mem_addr        byte address
//   mem_stor_data   store data, already placed in its byte lanes
//   mem_data        load data, right-justified
//   stall_o         freezes the upstream pipeline
//   misalign_o      one-cycle misaligned-access flag (optional feature)
//   req_*           bus request channel (valid/ready); address 8-byte aligned
//   resp_valid      read data / write acknowledge valid
//   resp_rdata      8-byte-aligned read data
//
// Optional feature:
//   Define YSYX_22040931_MISALIGN_CHK_EN to enable the alignment check.
//   A misaligned H/W/D access then skips the bus, clears mem_data and raises
//   misalign_o for the single DONE cycle. Without the macro no check is made,
//   misalign_o is tied low, and the strobe is truncated at lane 7.
// ---------------------------------------------------------------------------
module ysyx_22040931_lsu_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ena,
    input  logic              mem_wr,
    input  logic [1:0]        memop,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_stor_data,
    output logic [DATA_W-1:0] mem_data,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wr,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_wstrb,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              req_valid_q;
    logic              req_wr_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [7:0]        req_wstrb_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] mem_data_q;
    // Byte offset inside the 8-byte word. This is kept separately because
    // req_addr has its low bits cleared.
    logic [2:0]        off_q;

    // Byte-lane strobe for the access. Lanes shifted past bit 7 are dropped.
    function automatic logic [7:0] lane_strobe(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] base;
        case (sz)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Right-justify the addressed byte of an aligned read word, zero-filled.
    function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] d, input logic [2:0] off);
        return d >> {off, 3'b000};
    endfunction

`ifdef YSYX_22040931_MISALIGN_CHK_EN
    logic misalign_q;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wstrb_q <= '0;
            req_wdata_q <= '0;
            mem_data_q  <= '0;
            off_q       <= '0;
`ifdef YSYX_22040931_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // resp_valid is deliberately ignored here. A stray
                    // response, for example one that arrives after a reset,
                    // must not disturb mem_data.
                    if (mem_ena) begin
                        req_wr_q    <= mem_wr;
                        req_addr_q  <= {mem_addr[ADDR_W-1:3], 3'b000};
                        req_wstrb_q <= lane_strobe(memop, mem_addr[2:0]);
                        req_wdata_q <= mem_stor_data;
                        off_q       <= mem_addr[2:0];
`ifdef YSYX_22040931_MISALIGN_CHK_EN
                        if (is_misaligned(memop, mem_addr[2:0])) begin
                            state_q    <= DONE;
                            mem_data_q <= '0;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                        end
`else
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    // The req_* fields come from registers, so they stay
                    // stable until the bus accepts the request.
                    if (req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        state_q <= DONE;
                        if (!req_wr_q) begin
                            mem_data_q <= align_load(resp_rdata, off_q);
                        end
                    end
                end
                default: begin
                    // DONE: the pipeline advances this cycle. A new mem_ena
                    // is only taken once the controller is back in IDLE.
                    state_q <= IDLE;
`ifdef YSYX_22040931_MISALIGN_CHK_EN
                    misalign_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign stall_o   = ((state_q == IDLE) && mem_ena) || (state_q == REQ) || (state_q == WAIT);
    assign req_valid = req_valid_q;
    assign req_wr    = req_wr_q;
    assign req_addr  = req_addr_q;
    assign req_wstrb = req_wstrb_q;
    assign req_wdata = req_wdata_q;
    assign mem_data  = mem_data_q;

`ifdef YSYX_22040931_MISALIGN_CHK_EN
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040931_lsu_ctrl.sv
module tb_ysyx_22040931_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_ena;
    logic        mem_wr;
    logic [1:0]  memop;
    logic [63:0] mem_addr;
    logic [63:0] mem_stor_data;
    logic [63:0] mem_data;
    logic        stall_o;
    logic        misalign_o;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;

    ysyx_22040931_lsu_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ena       (mem_ena),
        .mem_wr        (mem_wr),
        .memop         (memop),
        .mem_addr      (mem_addr),
        .mem_stor_data (mem_stor_data),
        .mem_data      (mem_data),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wstrb     (req_wstrb),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        int          vld;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic        mis;
        int          stall;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_req(input logic wr, input logic [63:0] addr, input logic [7:0] strb,
                            input logic [63:0] wdata, input int vld);
        req_t e;
        e.wr = wr; e.addr = addr; e.strb = strb; e.wdata = wdata; e.vld = vld;
        req_q.push_back(e);
    endtask

    task automatic push_done(input logic [63:0] data, input logic mis, input int stall);
        done_t e;
        e.data = data; e.mis = mis; e.stall = stall;
        done_q.push_back(e);
    endtask

    // Monitor: checks every request beat against the head of req_q and every
    // completion (falling edge of stall_o) against the head of done_q.
    initial begin
        int vld_cnt;
        int stall_cnt;
        bit prev_stall;
        req_t  r;
        done_t d;
        vld_cnt = 0;
        stall_cnt = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                vld_cnt = 0;
                stall_cnt = 0;
                prev_stall = 1'b0;
            end else begin
                if (req_valid) begin
                    vld_cnt++;
                    if (req_q.size() == 0) begin
                        fail("unexpected_req");
                    end else begin
                        r = req_q[0];
                        chk("req_wr", {63'd0, req_wr}, {63'd0, r.wr});
                        chk("req_addr", req_addr, r.addr);
                        chk("req_wstrb", {56'd0, req_wstrb}, {56'd0, r.strb});
                        chk("req_wdata", req_wdata, r.wdata);
                        if (req_ready) begin
                            chk("req_valid_cycles", 64'(vld_cnt), 64'(r.vld));
                            void'(req_q.pop_front());
                            vld_cnt = 0;
                        end
                    end
                end
                if (stall_o) begin
                    stall_cnt++;
                    prev_stall = 1'b1;
                end else if (prev_stall) begin
                    if (done_q.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        d = done_q.pop_front();
                        chk("mem_data", mem_data, d.data);
                        chk("misalign_o", {63'd0, misalign_o}, {63'd0, d.mis});
                        chk("stall_cycles", 64'(stall_cnt), 64'(d.stall));
                    end
                    stall_cnt = 0;
                    prev_stall = 1'b0;
                end
            end
        end
    end

    // One access. After the request is latched, the mem_* inputs are
    // scrambled so that the DUT is forced to use its latched copy.
    task automatic access(input logic wr, input logic [1:0] op, input logic [63:0] addr,
                          input logic [63:0] sdata, input int rdy_dly, input int resp_dly,
                          input logic [63:0] rdata, input bit bus);
        int n;
        mem_ena = 1'b1; mem_wr = wr; memop = op; mem_addr = addr; mem_stor_data = sdata;
        @(posedge clk); #1;
        mem_ena = 1'b0; mem_wr = ~wr; memop = ~op; mem_addr = ~addr; mem_stor_data = ~sdata;
        if (bus) begin
            repeat (rdy_dly) begin @(posedge clk); #1; end
            req_ready = 1'b1;
            n = 0;
            while (req_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) fail("req_timeout");
            @(posedge clk); #1;
            req_ready = 1'b0;
            repeat (resp_dly) begin @(posedge clk); #1; end
            resp_valid = 1'b1; resp_rdata = rdata;
            @(posedge clk); #1;
            resp_valid = 1'b0; resp_rdata = 64'h0;
        end
        @(posedge clk); #1;
    endtask

    logic [63:0] exp_mem;

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ena = 1'b0; mem_wr = 1'b0; memop = 2'b00; mem_addr = 64'h0;
        mem_stor_data = 64'h0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and idle behaviour
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_req_wr", {63'd0, req_wr}, 64'd0);
        chk("rst_req_addr", req_addr, 64'd0);
        chk("rst_req_wstrb", {56'd0, req_wstrb}, 64'd0);
        chk("rst_req_wdata", req_wdata, 64'd0);
        chk("rst_mem_data", mem_data, 64'd0);
        chk("rst_misalign", {63'd0, misalign_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_stall", {63'd0, stall_o}, 64'd0);
        chk("idle_req_valid", {63'd0, req_valid}, 64'd0);

        // Load D, aligned
        push_req(1'b0, 64'h80000008, 8'hFF, 64'h0, 1);
        push_done(64'h1122334455667788, 1'b0, 3);
        access(1'b0, 2'b11, 64'h80000008, 64'h0, 0, 0, 64'h1122334455667788, 1'b1);

        // Load B at offset 5
        push_req(1'b0, 64'h80000000, 8'h20, 64'h0, 1);
        push_done(64'h0000000000AABBCC, 1'b0, 3);
        access(1'b0, 2'b00, 64'h80000005, 64'h0, 0, 0, 64'hAABBCCDDEEFF0011, 1'b1);

        // Store H at offset 6 with req_ready held off 4 cycles
        push_req(1'b1, 64'h80000000, 8'hC0, 64'hBEEF000000000000, 5);
        push_done(64'h0000000000AABBCC, 1'b0, 7);
        access(1'b1, 2'b01, 64'h80000006, 64'hBEEF000000000000, 4, 0, 64'hDEADBEEFDEADBEEF, 1'b1);

        // Load W at offset 4 with a response 2 cycles late
        push_req(1'b0, 64'h80000010, 8'hF0, 64'h0, 1);
        push_done(64'h0000000001234567, 1'b0, 5);
        access(1'b0, 2'b10, 64'h80000014, 64'h0, 0, 2, 64'h0123456789ABCDEF, 1'b1);

        // Load H at offset 7: misaligned, or a truncated strobe
`ifdef YSYX_22040931_MISALIGN_CHK_EN
        push_done(64'h0, 1'b1, 1);
        access(1'b0, 2'b01, 64'h80000007, 64'h0, 0, 0, 64'h8877665544332211, 1'b0);
        exp_mem = 64'h0;
`else
        push_req(1'b0, 64'h80000000, 8'h80, 64'h0, 1);
        push_done(64'h0000000000000088, 1'b0, 3);
        access(1'b0, 2'b01, 64'h80000007, 64'h0, 0, 0, 64'h8877665544332211, 1'b1);
        exp_mem = 64'h88;
`endif

        // Store D with req_ready one cycle late; mem_data is unchanged
        push_req(1'b1, 64'h80000020, 8'hFF, 64'h0102030405060708, 2);
        push_done(exp_mem, 1'b0, 4);
        access(1'b1, 2'b11, 64'h80000020, 64'h0102030405060708, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1'b1);

        // Reset while in WAIT, then a late response
        push_req(1'b0, 64'h80000000, 8'hFF, 64'h0, 1);
        mem_ena = 1'b1; mem_wr = 1'b0; memop = 2'b11; mem_addr = 64'h80000000; mem_stor_data = 64'h0;
        @(posedge clk); #1;
        mem_ena = 1'b0; req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("wrst_stall", {63'd0, stall_o}, 64'd0);
        chk("wrst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("wrst_mem_data", mem_data, 64'd0);
        resp_valid = 1'b1; resp_rdata = 64'hCAFEF00DCAFEF00D;
        @(posedge clk); #1;
        resp_valid = 1'b0; resp_rdata = 64'h0;
        @(posedge clk); #1;
        chk("late_resp_mem_data", mem_data, 64'd0);
        chk("late_resp_stall", {63'd0, stall_o}, 64'd0);

        // Load W at offset 2
`ifdef YSYX_22040931_MISALIGN_CHK_EN
        push_done(64'h0, 1'b1, 1);
        access(1'b0, 2'b10, 64'h80000002, 64'h0, 0, 0, 64'h0011223344556677, 1'b0);
`else
        push_req(1'b0, 64'h80000000, 8'h3C, 64'h0, 1);
        push_done(64'h0000001122334455, 1'b0, 3);
        access(1'b0, 2'b10, 64'h80000002, 64'h0, 0, 0, 64'h0011223344556677, 1'b1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        chk("end_misalign", {63'd0, misalign_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040931_lsu_ctrl.md
Name: ysyx_22040931_lsu_ctrl

Overview:
Data-memory access controller directly downstream of the MEM stage. Consumes mem_ena/mem_wr/mem_addr/memop/mem_stor_data and runs one transaction on a valid/ready data bus. Returns right-justified load data on mem_data for MEM-stage sign/zero extension. Holds the pipeline with stall_o until the access completes.

Parameters:
ADDR_W, 64, request address width (matches MEM_BUS)
DATA_W, 64, data width; fixed 8 byte lanes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_ena  in  1  access request from MEM stage
mem_wr  in  1  1=store, 0=load
memop  in  2  size: 00=B, 01=H, 10=W, 11=D
mem_addr  in  ADDR_W  byte address
mem_stor_data  in  64  store data, already shifted into its byte lanes
mem_data  out  64  load data, right-justified (addressed byte at bit 0)
stall_o  out  1  freeze upstream pipeline
misalign_o  out  1  one-cycle misaligned-access flag (optional feature only)
req_valid  out  1  bus request valid
req_ready  in  1  bus accepts request
req_wr  out  1  request is a write
req_addr  out  ADDR_W  mem_addr with [2:0] forced to 0
req_wstrb  out  8  byte strobes
req_wdata  out  64  store data
resp_valid  in  1  read data / write ack valid
resp_rdata  in  64  8-byte-aligned read data

Behaviour:
- Clock and reset: one clock; synchronous active-high reset on rst.
- States: IDLE, REQ, WAIT, DONE.
- Reset values: state=IDLE, req_valid=0, req_wr=0, req_addr=0, req_wstrb=0, req_wdata=0, mem_data=0, misalign_o=0.
- IDLE: when mem_ena=1, latch addr, size, wr and data, and compute the strobe; next state is REQ. When mem_ena=0, stay in IDLE. resp_valid is ignored in IDLE.
- Strobe: base mask B=0x01, H=0x03, W=0x0F, D=0xFF, shifted left by addr[2:0]. Bits beyond lane 7 are dropped.
- REQ: req_valid=1. Latched fields are driven on the req_* outputs and held stable until req_ready. When req_valid&req_ready, next state is WAIT.
- WAIT: req_valid=0. When resp_valid, next state is DONE.
  - Loads: capture mem_data = resp_rdata >> (addr[2:0]*8), zero-filled.
  - Stores: leave mem_data unchanged.
- A response in the same cycle as acceptance is not supported. The bus must give resp_valid at least one cycle after req_ready.
- DONE: one cycle. stall_o=0 so the pipeline advances. mem_data holds the captured value. Next state is IDLE unconditionally; a new mem_ena is not sampled in DONE.
- stall_o (combinational) = (state==IDLE & mem_ena) | state==REQ | state==WAIT.
- Minimum access: stall_o high for 3 cycles (IDLE, REQ with req_ready=1, WAIT with resp_valid=1), then low in DONE.
- Input stability: changes on mem_* inputs while in REQ or WAIT are ignored; the latched copy is used.
- Reset mid-operation: state goes to IDLE and req_valid drops in the same edge. A late resp_valid after reset is discarded.
- mem_data holds its value across IDLE until the next load completes.

Optional Feature:
- Macro: YSYX_22040931_MISALIGN_CHK_EN.
- With the macro defined:
  - In IDLE with mem_ena, check alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - On failure, no bus request is issued. Next state is DONE directly, mem_data is cleared to 0, and misalign_o=1 for exactly the DONE cycle.
- Without the macro: no check is made, and misalign_o is tied to 0. The truncated strobe is issued as defined in Behaviour.

Test Plan:
- Reset, then idle: outputs hold reset values; stall_o=0 while mem_ena=0.
- Load D, addr 0x80000008, req_ready=1 immediately, resp_rdata=0x1122334455667788 one cycle later -> req_addr=0x80000008, req_wstrb=0xFF, stall_o high 3 cycles, mem_data=0x1122334455667788 in DONE.
- Load B, addr 0x80000005, rdata=0xAABBCCDDEEFF0011 -> mem_data=0x0000000000AABBCC, req_addr=0x80000000.
- Store H, addr 0x80000006, data lane-aligned 0xBEEF000000000000, req_ready delayed 4 cycles -> req_valid and req_wstrb=0xC0 held stable for 5 cycles, stall_o high until after resp_valid, mem_data unchanged.
- rst asserted while in WAIT, then resp_valid pulses -> state IDLE, req_valid=0, mem_data=0, stall_o=0, response ignored.
- With YSYX_22040931_MISALIGN_CHK_EN: load W at addr 0x80000002 -> req_valid never asserted, misalign_o=1 for one cycle, stall_o high 1 cycle, mem_data=0.
